// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one 8-bit AXI-stream TX input between
// PORTS requesters. Grant is held from the first beat to tlast; frames longer than
// MAX_FRAME_LEN are cut short, marked bad (tuser=1) and the remainder is drained.
module eth_tx_frame_arbiter #(
    parameter int unsigned PORTS         = 2,
    parameter int unsigned MAX_FRAME_LEN = 1514,
    localparam int unsigned IW           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [8*PORTS-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]   s_axis_tvalid,
    output logic [PORTS-1:0]   s_axis_tready,
    input  logic [PORTS-1:0]   s_axis_tlast,
    input  logic [PORTS-1:0]   s_axis_tuser,
    output logic [7:0]         m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               m_axis_tuser,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx,
    output logic               oversize_pulse
);

    typedef enum logic [1:0] {StIdle, StPass, StDrain} state_e;

    localparam logic [15:0]   LastCnt = 16'(MAX_FRAME_LEN - 1);
    localparam logic [IW-1:0] RrInit  = IW'(PORTS - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   rr_last_q, rr_last_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic            oversize_q, oversize_d;

    logic [7:0]      sel_data;
    logic            sel_valid, sel_last, sel_user;
    logic            win_found;
    logic [IW-1:0]   win_idx, cand;
    logic            at_limit, trunc_beat;

    // Mux the granted requester's stream signals.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (grant_q == IW'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    // Round-robin search starting just after the last served port, wrapping mod PORTS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_last_q;
        cand      = '0;
        for (int k = 1; k <= int'(PORTS); k++) begin
            cand = IW'((int'(rr_last_q) + k) % int'(PORTS));
            if (!win_found && s_axis_tvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign at_limit   = (byte_cnt_q == LastCnt);
    assign trunc_beat = (state_q == StPass) && at_limit;

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            rr_last_q  <= RrInit;
            byte_cnt_q <= '0;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            byte_cnt_q <= byte_cnt_d;
            oversize_q <= oversize_d;
        end
    end

    // Next-state: grant on request, count beats, end on tlast or truncate at the limit.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        byte_cnt_d = byte_cnt_q;
        oversize_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d    = win_idx;
                    byte_cnt_d = '0;
                    state_d    = StPass;
                end
            end
            StPass: begin
                if (sel_valid && m_axis_tready) begin
                    if (byte_cnt_q != 16'hFFFF) begin
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                    if (sel_last) begin
                        state_d   = StIdle;
                        rr_last_d = grant_q;
                    end else if (at_limit) begin
                        state_d    = StDrain;
                        oversize_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (sel_valid && sel_last) begin
                    state_d   = StIdle;
                    rr_last_d = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: pass-through in PASS, swallow in DRAIN, all quiet while in reset.
    always_comb begin
        m_axis_tdata  = sel_data;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = sel_last | trunc_beat;
        m_axis_tuser  = sel_user | (trunc_beat & ~sel_last);
        s_axis_tready = '0;
        if (rst_n) begin
            unique case (state_q)
                StPass: begin
                    m_axis_tvalid          = sel_valid;
                    s_axis_tready[grant_q] = m_axis_tready;
                end
                StDrain: s_axis_tready[grant_q] = 1'b1;
                default: ;
            endcase
        end
    end

    assign grant_valid    = (state_q != StIdle);
    assign grant_idx      = grant_q;
    assign oversize_pulse = oversize_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter with two AXI-stream sources and MAX_FRAME_LEN=100.
module tb_eth_tx_frame_arbiter;

    localparam int P    = 2;
    localparam int MAXL = 100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [15:0]  s_axis_tdata;
    logic [1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]   m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic         grant_valid;
    logic [0:0]   grant_idx;
    logic         oversize_pulse;

    always #4 clk = ~clk;

    eth_tx_frame_arbiter #(.PORTS(P), .MAX_FRAME_LEN(MAXL)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .grant_valid    (grant_valid),
        .grant_idx      (grant_idx),
        .oversize_pulse (oversize_pulse)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
        int         port;
        int         cyc;
    } beat_t;

    beat_t mq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int inv_err = 0;
    int pulse_cnt = 0;
    int pulse_cyc = -1;
    int mirror_err = 0;
    int mirror_seen = 0;
    int held_cnt = 0;
    bit chk_mirror = 0;
    bit tog_ready = 0;
    logic samp_m_tvalid;

    // Source model state per port.
    int src_len[P];
    int src_idx[P];
    int src_frames[P];
    int src_fnum[P];
    int src_gap_at[P];
    int src_gap_rem[P];
    bit src_active[P];

    function automatic logic [7:0] exp_byte(input int p, input int f, input int i);
        return 8'((p * 128 + f * 3 + i) & 255);
    endfunction

    task automatic drive_inputs();
        for (int p = 0; p < P; p++) begin
            s_axis_tuser[p] = 1'b0;
            if (src_active[p]) begin
                s_axis_tdata[8*p +: 8] = exp_byte(p, src_fnum[p], src_idx[p]);
                s_axis_tlast[p] = (src_idx[p] == src_len[p] - 1);
                if (src_idx[p] == src_gap_at[p] && src_gap_rem[p] > 0) begin
                    s_axis_tvalid[p] = 1'b0;
                    src_gap_rem[p]--;
                end else begin
                    s_axis_tvalid[p] = 1'b1;
                end
            end else begin
                s_axis_tdata[8*p +: 8] = 8'h00;
                s_axis_tlast[p]  = 1'b0;
                s_axis_tvalid[p] = 1'b0;
            end
        end
    endtask

    task automatic start_frame(input int p, input int len, input int frames,
                               input int gap_at, input int gap_len);
        src_len[p]     = len;
        src_idx[p]     = 0;
        src_frames[p]  = frames;
        src_fnum[p]    = 0;
        src_gap_at[p]  = gap_at;
        src_gap_rem[p] = gap_len;
        src_active[p]  = 1'b1;
        drive_inputs();
    endtask

    // One cycle: monitor at negedge, then advance sources just after the posedge.
    task automatic step();
        bit [P-1:0] hs;
        beat_t b;
        @(negedge clk);
        hs = s_axis_tvalid & s_axis_tready;
        samp_m_tvalid = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            b.data = m_axis_tdata;
            b.last = m_axis_tlast;
            b.user = m_axis_tuser;
            b.port = int'(grant_idx);
            b.cyc  = cyc;
            mq.push_back(b);
        end
        if ($countones(s_axis_tready) > 1) inv_err++;
        if (m_axis_tvalid && !grant_valid) inv_err++;
        if (oversize_pulse) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
        if (chk_mirror && grant_valid) begin
            mirror_seen++;
            if (s_axis_tready[1] !== m_axis_tready) mirror_err++;
        end
        if (chk_mirror && s_axis_tready[0] !== 1'b0) mirror_err++;
        if (!s_axis_tvalid[0] && s_axis_tvalid[1] && src_active[0] && grant_valid
            && grant_idx == 1'b0) held_cnt++;
        @(posedge clk);
        cyc++;
        #1;
        for (int p = 0; p < P; p++) begin
            if (hs[p]) begin
                if (src_idx[p] == src_len[p] - 1) begin
                    src_frames[p]--;
                    if (src_frames[p] > 0) begin
                        src_fnum[p]++;
                        src_idx[p] = 0;
                    end else begin
                        src_active[p] = 1'b0;
                    end
                end else begin
                    src_idx[p]++;
                end
            end
        end
        if (tog_ready) m_axis_tready = ~m_axis_tready;
        drive_inputs();
    endtask

    task automatic run_idle(input int budget, input string name);
        int n = 0;
        while ((src_active[0] || src_active[1] || grant_valid) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < P; p++) src_active[p] = 1'b0;
        drive_inputs();
        m_axis_tready = 1'b1;
        tog_ready = 1'b0;
        chk_mirror = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tdata = 16'h5a5a;
        s_axis_tvalid = 2'b11;
        s_axis_tlast = 2'b00;
        s_axis_tuser = 2'b00;
        for (int p = 0; p < P; p++) src_active[p] = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_tvalid: got %b required 0", m_axis_tvalid);
        end
        checks++;
        if (s_axis_tready !== 2'b00) begin
            errors++;
            $display("FAIL reset_tready: got %b required 00", s_axis_tready);
        end
        checks++;
        if (grant_valid !== 1'b0 || grant_idx !== 1'b0 || oversize_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gv=%b gi=%b ov=%b required 0 0 0",
                     grant_valid, grant_idx, oversize_pulse);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
    endtask

    task automatic test_single_frame();
        int bad = 0;
        mq.delete();
        start_frame(0, 64, 1, -1, 0);
        step();
        checks++;
        if (samp_m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_cycle: tvalid got %b required 0", samp_m_tvalid);
        end
        step();
        checks++;
        if (samp_m_tvalid !== 1'b1 || grant_idx !== 1'b0) begin
            errors++;
            $display("FAIL single_first_beat: tvalid=%b gi=%b required 1 0",
                     samp_m_tvalid, grant_idx);
        end
        run_idle(300, "single");
        checks++;
        if (mq.size() != 64) begin
            errors++;
            $display("FAIL single_count: got %0d beats required 64", mq.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (mq[i].data !== exp_byte(0, 0, i) || mq[i].last !== (i == 63) ||
                    mq[i].user !== 1'b0 || mq[i].port != 0 || mq[i].cyc != mq[0].cyc + i)
                    bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL single_beats: %0d bad beats, required 0", bad);
            end
        end
        checks++;
        if (grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: grant_valid got %b required 0", grant_valid);
        end
    endtask

    task automatic test_round_robin();
        int bad_order = 0, bad_data = 0, bad_cont = 0, bad_gap = 0;
        do_reset();
        mq.delete();
        start_frame(0, 60, 3, -1, 0);
        start_frame(1, 60, 3, -1, 0);
        run_idle(1000, "rr");
        checks++;
        if (mq.size() != 360) begin
            errors++;
            $display("FAIL rr_count: got %0d beats required 360", mq.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                for (int i = 0; i < 60; i++) begin
                    if (mq[60*k+i].port != k % 2) bad_order++;
                    if (mq[60*k+i].data !== exp_byte(k % 2, k / 2, i) ||
                        mq[60*k+i].last !== (i == 59) || mq[60*k+i].user !== 1'b0) bad_data++;
                    if (i > 0 && mq[60*k+i].cyc != mq[60*k+i-1].cyc + 1) bad_cont++;
                end
                if (k < 5 && mq[60*k+60].cyc != mq[60*k+59].cyc + 2) bad_gap++;
            end
            checks++;
            if (bad_order != 0) begin
                errors++;
                $display("FAIL rr_order: %0d beats on wrong port, required 0", bad_order);
            end
            checks++;
            if (bad_data != 0) begin
                errors++;
                $display("FAIL rr_data: %0d bad beats, required 0", bad_data);
            end
            checks++;
            if (bad_cont != 0 || bad_gap != 0) begin
                errors++;
                $display("FAIL rr_timing: cont=%0d gap=%0d required 0 0", bad_cont, bad_gap);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        mq.delete();
        mirror_err = 0;
        mirror_seen = 0;
        m_axis_tready = 1'b1;
        start_frame(1, 8, 1, -1, 0);
        chk_mirror = 1'b1;
        tog_ready = 1'b1;
        run_idle(200, "bp");
        chk_mirror = 1'b0;
        tog_ready = 1'b0;
        m_axis_tready = 1'b1;
        checks++;
        if (mirror_err != 0 || mirror_seen <= 8) begin
            errors++;
            $display("FAIL bp_mirror: errs=%0d granted_cycles=%0d required 0 and >8",
                     mirror_err, mirror_seen);
        end
        checks++;
        if (mq.size() != 8) begin
            errors++;
            $display("FAIL bp_count: got %0d beats required 8", mq.size());
        end else begin
            for (int i = 0; i < 8; i++)
                if (mq[i].data !== exp_byte(1, 0, i) || mq[i].last !== (i == 7) ||
                    mq[i].port != 1) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL bp_beats: %0d bad beats, required 0", bad);
            end
        end
    endtask

    task automatic test_oversize();
        int bad = 0;
        do_reset();
        mq.delete();
        pulse_cnt = 0;
        pulse_cyc = -1;
        start_frame(0, 150, 1, -1, 0);
        start_frame(1, 10, 1, -1, 0);
        run_idle(600, "ovs");
        checks++;
        if (mq.size() != 110) begin
            errors++;
            $display("FAIL ovs_count: got %0d beats required 110", mq.size());
        end else begin
            for (int i = 0; i < 100; i++)
                if (mq[i].port != 0 || mq[i].data !== exp_byte(0, 0, i) ||
                    mq[i].last !== (i == 99) || mq[i].user !== (i == 99)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ovs_trunc_beats: %0d bad beats, required 0", bad);
            end
            bad = 0;
            for (int i = 0; i < 10; i++)
                if (mq[100+i].port != 1 || mq[100+i].data !== exp_byte(1, 0, i) ||
                    mq[100+i].last !== (i == 9) || mq[100+i].user !== 1'b0) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL ovs_next_port: %0d bad beats, required 0", bad);
            end
            checks++;
            if (pulse_cnt != 1 || pulse_cyc != mq[99].cyc + 1) begin
                errors++;
                $display("FAIL ovs_pulse: count=%0d at=%0d required 1 at %0d",
                         pulse_cnt, pulse_cyc, mq[99].cyc + 1);
            end
        end
    endtask

    task automatic test_valid_gap();
        int bad = 0;
        do_reset();
        mq.delete();
        held_cnt = 0;
        start_frame(0, 40, 1, 10, 20);
        start_frame(1, 5, 1, -1, 0);
        run_idle(300, "gap");
        checks++;
        if (held_cnt != 20) begin
            errors++;
            $display("FAIL gap_hold: grant held %0d idle cycles, required 20", held_cnt);
        end
        checks++;
        if (mq.size() != 45) begin
            errors++;
            $display("FAIL gap_count: got %0d beats required 45", mq.size());
        end else begin
            for (int i = 0; i < 45; i++) begin
                if (i < 40 && (mq[i].port != 0 || mq[i].data !== exp_byte(0, 0, i))) bad++;
                if (i >= 40 && (mq[i].port != 1 || mq[i].data !== exp_byte(1, 0, i - 40))) bad++;
            end
            checks++;
            if (bad != 0 || mq[10].cyc != mq[9].cyc + 21) begin
                errors++;
                $display("FAIL gap_beats: bad=%0d stall=%0d required 0 and 21",
                         bad, mq[10].cyc - mq[9].cyc);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0, bad = 0;
        mq.delete();
        start_frame(0, 4, 1, -1, 0);
        run_idle(100, "mid_pre");
        mq.delete();
        start_frame(1, 80, 1, -1, 0);
        while (!(src_idx[1] == 29 && grant_valid) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL mid_reach_beat30: idx=%0d required 29", src_idx[1]);
        end
        rst_n = 1'b0;
        for (int p = 0; p < P; p++) src_active[p] = 1'b0;
        drive_inputs();
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 2'b00) begin
            errors++;
            $display("FAIL mid_in_reset: tvalid=%b tready=%b required 0 00",
                     m_axis_tvalid, s_axis_tready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 2'b00 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after_reset: tvalid=%b tready=%b gv=%b required 0 00 0",
                     m_axis_tvalid, s_axis_tready, grant_valid);
        end
        for (int i = 0; i < mq.size(); i++) if (mq[i].last !== 1'b0 || mq[i].port != 1) bad++;
        checks++;
        if (mq.size() != 29 || bad != 0) begin
            errors++;
            $display("FAIL mid_partial: beats=%0d bad=%0d required 29 0", mq.size(), bad);
        end
        @(posedge clk);
        #1;
        mq.delete();
        start_frame(0, 5, 1, -1, 0);
        start_frame(1, 5, 1, -1, 0);
        run_idle(100, "mid_post");
        checks++;
        if (mq.size() != 10 || mq[0].port != 0 || mq[5].port != 1) begin
            errors++;
            $display("FAIL mid_rr_restart: beats=%0d first_port=%0d required 10 and 0",
                     mq.size(), (mq.size() > 0) ? mq[0].port : -1);
        end
    endtask

    initial begin
        for (int p = 0; p < P; p++) begin
            src_active[p] = 1'b0;
            src_gap_at[p] = -1;
            src_gap_rem[p] = 0;
        end
        test_reset();
        test_single_frame();
        test_round_robin();
        test_backpressure();
        test_oversize();
        test_valid_gap();
        test_reset_mid_frame();
        checks++;
        if (inv_err != 0) begin
            errors++;
            $display("FAIL invariants: %0d violations, required 0", inv_err);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
